// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Sequences the IF/ID and ID/EX pipeline registers of the 5-stage core.
// Every cycle it decides whether the PC and IF/ID advance, hold or flush,
// and whether ID/EX loads, holds or takes a bubble. It also turns a stuck
// instruction fetch into a sticky fault and counts stall cycles.
//
// Ports
//   clk, reset        clock (rising edge), synchronous active-high reset
//   id_rs1/id_rs2     source registers of the ID instruction
//   id_uses_rs1/rs2   ID instruction actually reads rs1 / rs2
//   ex_mem_read       EX instruction is a load
//   ex_rd             EX destination register
//   branch_taken      EX resolved a taken branch/jump this cycle
//   ex_busy           multi-cycle EX unit not finished
//   imem_ready        instruction memory data valid this cycle
//   pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble
//                     pipeline register controls (combinational)
//   fault             fetch timeout, sticky until reset
//   state             RUN=0, FLUSH=1, WAIT_IMEM=2, FAULT=3
//   stall_cycles      saturating count of cycles with pc_write=0
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | normal issue; resolves branch > busy > load-use > fetch
// FLUSH     | extra bubble cycles after a taken branch
// WAIT_IMEM | fetch outstanding; timer counts not-ready cycles
// FAULT     | fetch timed out; pipeline frozen until reset

module pipeline_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int IMEM_TIMEOUT = 15,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             branch_taken,
   input  logic             ex_busy,
   input  logic             imem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             fault,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
   localparam int TM_W = $clog2(IMEM_TIMEOUT + 1);
   localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [TM_W-1:0]  TM_LIMIT   = TM_W'(IMEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_FLUSH     = 2'd1,
      ST_WAIT_IMEM = 2'd2,
      ST_FAULT     = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ACT_ADVANCE,
      ACT_FLUSH,
      ACT_HOLD,
      ACT_STALL
   } act_t;

   state_t           state_q, state_d;
   logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [TM_W-1:0]  fetch_tmr_q, fetch_tmr_d;
   logic [CNT_W-1:0] stall_q;
   act_t             act;
   logic             load_use;

   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      act         = ACT_HOLD;
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      fetch_tmr_d = fetch_tmr_q;
      case (state_q)
         ST_RUN, ST_WAIT_IMEM: begin
            if (branch_taken) begin
               // Any fetch in flight is dropped along with the wrong path.
               act         = ACT_FLUSH;
               fetch_tmr_d = '0;
               if (FLUSH_CYCLES > 1) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = FLUSH_LOAD;
               end else begin
                  state_d = ST_RUN;
               end
            end else if (ex_busy) begin
               act = ACT_HOLD;
            end else if (load_use) begin
               act = ACT_STALL;
            end else if (!imem_ready) begin
               act = ACT_STALL;
               // Timer holds the number of not-ready cycles seen so far,
               // including the RUN cycle that first saw the miss.
               if (state_q == ST_RUN) begin
                  fetch_tmr_d = TM_W'(1);
                  state_d     = (IMEM_TIMEOUT == 1) ? ST_FAULT : ST_WAIT_IMEM;
               end else begin
                  fetch_tmr_d = fetch_tmr_q + TM_W'(1);
                  if ((fetch_tmr_q + TM_W'(1)) == TM_LIMIT) begin
                     state_d = ST_FAULT;
                  end
               end
            end else begin
               act         = ACT_ADVANCE;
               state_d     = ST_RUN;
               fetch_tmr_d = '0;
            end
         end
         ST_FLUSH: begin
            act         = ACT_FLUSH;
            flush_cnt_d = flush_cnt_q - FC_W'(1);
            if (flush_cnt_q == FC_W'(1)) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            act = ACT_HOLD;
         end
      endcase
   end

   always_comb begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b0;
      id_ex_bubble = 1'b0;
      if (reset) begin
         // Fill the pipe with NOPs while reset is held.
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else begin
         case (act)
            ACT_ADVANCE: begin
               pc_write    = 1'b1;
               if_id_write = 1'b1;
               id_ex_write = 1'b1;
            end
            ACT_FLUSH: begin
               pc_write     = 1'b1;
               if_id_write  = 1'b1;
               if_id_flush  = 1'b1;
               id_ex_write  = 1'b1;
               id_ex_bubble = 1'b1;
            end
            ACT_STALL: begin
               id_ex_write  = 1'b1;
               id_ex_bubble = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign fault        = (state_q == ST_FAULT) && !reset;
   assign state        = state_q;
   assign stall_cycles = stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= '0;
         fetch_tmr_q <= '0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         fetch_tmr_q <= fetch_tmr_d;
         if (!pc_write && (state_q != ST_FAULT) && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, IMEM_TIMEOUT=15, CNT_W=4).
// Each record holds one cycle of inputs plus the control pattern, fault,
// state and stall count expected during that cycle (before the edge).
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
   logic       branch_taken, ex_busy, imem_ready;
   logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
   logic       fault;
   logic [1:0] state;
   logic [3:0] stall_cycles;

   pipeline_hazard_ctrl #(
      .FLUSH_CYCLES(2),
      .IMEM_TIMEOUT(15),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .id_rs1(id_rs1),
      .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd),
      .branch_taken(branch_taken),
      .ex_busy(ex_busy),
      .imem_ready(imem_ready),
      .pc_write(pc_write),
      .if_id_write(if_id_write),
      .if_id_flush(if_id_flush),
      .id_ex_write(id_ex_write),
      .id_ex_bubble(id_ex_bubble),
      .fault(fault),
      .state(state),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   typedef enum int {A_ADV, A_FL, A_HOLD, A_STALL, A_RST} act_t;

   typedef struct {
      bit       rst;
      bit       rdy;
      bit       br;
      bit       busy;
      bit       mr;
      bit [4:0] rd;
      bit [4:0] rs1;
      bit       u1;
      bit [4:0] rs2;
      bit       u2;
      act_t     a;
      bit       flt;
      bit [1:0] st;
      bit [3:0] sc;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble}
   function automatic bit [4:0] act_bits(act_t a);
      case (a)
         A_ADV:   return 5'b11010;
         A_FL:    return 5'b11111;
         A_STALL: return 5'b00011;
         A_RST:   return 5'b00101;
         default: return 5'b00000;
      endcase
   endfunction

   function automatic vec_t mk(bit rst, bit rdy, bit br, bit busy, bit mr,
                               bit [4:0] rd, bit [4:0] rs1, bit u1,
                               bit [4:0] rs2, bit u2,
                               act_t a, bit flt, bit [1:0] st, bit [3:0] sc);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.br = br; v.busy = busy; v.mr = mr;
      v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
      v.a = a; v.flt = flt; v.st = st; v.sc = sc;
      return v;
   endfunction

   function automatic vec_t idle(act_t a, bit [1:0] st, bit [3:0] sc);
      return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, a, 0, st, sc);
   endfunction

   task automatic cmp(string name, int idx, int act_v, int exp_v);
      n_cmp++;
      if (act_v != exp_v) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act_v, exp_v);
      end
   endtask

   task automatic drive(vec_t v);
      reset        = v.rst;
      imem_ready   = v.rdy;
      branch_taken = v.br;
      ex_busy      = v.busy;
      ex_mem_read  = v.mr;
      ex_rd        = v.rd;
      id_rs1       = v.rs1;
      id_uses_rs1  = v.u1;
      id_rs2       = v.rs2;
      id_uses_rs2  = v.u2;
      exp_q.push_back(v);
   endtask

   task automatic check(int idx);
      vec_t e;
      if (exp_q.size() == 0) begin
         cmp("scoreboard_empty", idx, 1, 0);
         return;
      end
      e = exp_q.pop_front();
      cmp("ctrl", idx,
          int'({pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble}),
          int'(act_bits(e.a)));
      cmp("fault", idx, int'(fault), int'(e.flt));
      cmp("state", idx, int'(state), int'(e.st));
      cmp("stall_cycles", idx, int'(stall_cycles), int'(e.sc));
   endtask

   int step = 0;

   task automatic apply(vec_t v);
      @(negedge clk);
      drive(v);
      #1;
      check(step);
      step++;
   endtask

   initial begin
      // Table: load-use, register-0 and unused-operand cases, branch with
      // concurrent hazards, ex_busy hold, short fetch miss, branch in WAIT_IMEM.
      tbl.push_back(mk(1,1,0,0,0, 0,0,0,0,0, A_RST,  0, 0, 0));
      tbl.push_back(idle(A_ADV, 0, 0));
      tbl.push_back(mk(0,1,0,0,1, 5,0,0,5,1, A_STALL,0, 0, 0));
      tbl.push_back(idle(A_ADV, 0, 1));
      tbl.push_back(mk(0,1,0,0,1, 0,0,1,0,0, A_ADV,  0, 0, 1));
      tbl.push_back(mk(0,1,0,0,1, 7,7,0,0,0, A_ADV,  0, 0, 1));
      tbl.push_back(mk(0,1,0,0,1, 9,9,1,0,0, A_STALL,0, 0, 1));
      tbl.push_back(idle(A_ADV, 0, 2));
      tbl.push_back(mk(0,1,1,1,1, 5,0,0,5,1, A_FL,   0, 0, 2));
      tbl.push_back(mk(0,0,1,0,1, 5,0,0,5,1, A_FL,   0, 1, 2));
      tbl.push_back(idle(A_ADV, 0, 2));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0,1,0,1,0, 0,0,0,0,0, A_HOLD, 0, 0, 4'(2 + i)));
      tbl.push_back(idle(A_ADV, 0, 6));
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, A_STALL,0, 0, 6));
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, A_STALL,0, 2, 7));
      tbl.push_back(idle(A_ADV, 2, 8));
      tbl.push_back(idle(A_ADV, 0, 8));
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, A_STALL,0, 0, 8));
      tbl.push_back(mk(0,0,1,0,0, 0,0,0,0,0, A_FL,   0, 2, 9));
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, A_FL,   0, 1, 9));
      tbl.push_back(idle(A_ADV, 0, 9));
      tbl.push_back(mk(1,1,0,0,0, 0,0,0,0,0, A_RST,  0, 0, 9));
      tbl.push_back(idle(A_ADV, 0, 0));

      // Initial reset, unchecked: state is unknown before the first edge.
      @(negedge clk);
      reset = 1; imem_ready = 1; branch_taken = 0; ex_busy = 0;
      ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
      id_uses_rs1 = 0; id_uses_rs2 = 0;
      @(posedge clk);
      @(posedge clk);

      foreach (tbl[i]) apply(tbl[i]);

      // Fetch timeout: 15 not-ready cycles, then FAULT from the next edge.
      for (int k = 1; k <= 15; k++)
         apply(mk(0,0,0,0,0, 0,0,0,0,0, A_STALL, 0, (k == 1) ? 2'd0 : 2'd2, 4'(k - 1)));
      for (int k = 0; k < 3; k++)
         apply(mk(0,1,0,0,0, 0,0,0,0,0, A_HOLD, 1, 3, 15));
      apply(mk(0,1,1,1,0, 0,0,0,0,0, A_HOLD, 1, 3, 15));
      apply(mk(1,1,0,0,0, 0,0,0,0,0, A_RST, 0, 3, 15));
      apply(idle(A_ADV, 0, 0));

      // Counter saturation under a 20-cycle ex_busy, then reset mid-hold.
      for (int k = 1; k <= 20; k++)
         apply(mk(0,1,0,1,0, 0,0,0,0,0, A_HOLD, 0, 0, (k > 16) ? 4'd15 : 4'(k - 1)));
      apply(mk(1,1,0,1,0, 0,0,0,0,0, A_RST, 0, 0, 15));
      apply(idle(A_ADV, 0, 0));
      apply(idle(A_ADV, 0, 0));

      // Reset while in FLUSH.
      apply(mk(0,1,1,0,0, 0,0,0,0,0, A_FL, 0, 0, 0));
      apply(mk(1,1,0,0,0, 0,0,0,0,0, A_RST, 0, 1, 0));
      apply(idle(A_ADV, 0, 0));

      if (exp_q.size() != 0) cmp("scoreboard_leftover", step, exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
